// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl
//   Decodes PS/2 set-2 bytes (make, F0 break, E0 extended) and tracks both
//   shift keys. Each plain make code is sent to an external combinational
//   scan-code-to-ASCII translator. The result is captured one cycle later and,
//   if it is non-zero, pushed into a first-word-fall-through FIFO that the CPU
//   drains.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   scan_valid/code     one-cycle strobe + received PS/2 byte
//   key_out, shift_out  translator inputs (scan code, shift flag)
//   ascii_in            translator output, sampled in the LOOKUP cycle
//   rd_en               CPU pop strobe
//   rd_data             FIFO head (8'h00 when empty)
//   empty, full         FIFO status
//   ovf                 sticky: a character was dropped because the FIFO was full
//   drop                sticky: a scan byte arrived during LOOKUP and was ignored
//   err_clr             clears ovf and drop; a set in the same cycle takes priority
//   irq                 data pending (~empty)
module kbd_scan_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic [7:0] key_out,
  output logic       shift_out,
  input  logic [7:0] ascii_in,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       ovf,
  output logic       drop,
  input  logic       err_clr,
  output logic       irq
);

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BRK     = 3'd1,
    S_EXT     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_LOOKUP  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    key_q, key_d;
  logic          lshift_q, lshift_d;
  logic          rshift_q, rshift_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          drop_q, drop_d;
  logic [7:0]    mem_q [DEPTH];

  logic empty_w, full_w;
  logic push_req, push, pop;

  assign empty_w = (cnt_q == '0);
  assign full_w  = (cnt_q == FULL_CNT);

  // A push into a full FIFO still succeeds when a pop frees a slot on the
  // same edge.
  assign push_req = (state_q == S_LOOKUP) && (ascii_in != 8'h00);
  assign pop      = rd_en && !empty_w;
  assign push     = push_req && (!full_w || pop);

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    // Scan-byte decoder
    case (state_q)
      S_IDLE: begin
        if (scan_valid) begin
          if (scan_code == SC_BRK)         state_d  = S_BRK;
          else if (scan_code == SC_EXT)    state_d  = S_EXT;
          else if (scan_code == SC_LSHIFT) lshift_d = 1'b1;
          else if (scan_code == SC_RSHIFT) rshift_d = 1'b1;
          else begin
            key_d   = scan_code;
            state_d = S_LOOKUP;
          end
        end
      end
      S_BRK: begin
        if (scan_valid) begin
          if (scan_code == SC_LSHIFT) lshift_d = 1'b0;
          if (scan_code == SC_RSHIFT) rshift_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_EXT: begin
        if (scan_valid) begin
          // Extended keys are never translated; only track the break prefix.
          state_d = (scan_code == SC_BRK) ? S_EXT_BRK : S_IDLE;
        end
      end
      S_EXT_BRK: begin
        if (scan_valid) state_d = S_IDLE;
      end
      S_LOOKUP: begin
        // Always exactly one cycle; the translator has settled on key_out.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // FIFO pointers and occupancy
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    // Sticky error flags: clear first so a same-cycle set overrides it.
    if (err_clr) begin
      ovf_d  = 1'b0;
      drop_d = 1'b0;
    end
    if (push_req && full_w && !pop)           ovf_d  = 1'b1;
    if ((state_q == S_LOOKUP) && scan_valid)  drop_d = 1'b1;
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      key_q    <= 8'h00;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage (data only, no reset; reads are masked while empty)
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wptr_q] <= ascii_in;
  end

  assign key_out   = key_q;
  assign shift_out = lshift_q | rshift_q;
  assign rd_data   = empty_w ? 8'h00 : mem_q[rptr_q];
  assign empty     = empty_w;
  assign full      = full_w;
  assign ovf       = ovf_q;
  assign drop      = drop_q;
  assign irq       = ~empty_w;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
module tb_kbd_scan_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic [7:0] key_out;
  logic       shift_out;
  logic [7:0] ascii_in;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty, full, ovf, drop, err_clr, irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kbd_scan_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .scan_valid(scan_valid), .scan_code(scan_code),
    .key_out(key_out), .shift_out(shift_out), .ascii_in(ascii_in),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .ovf(ovf), .drop(drop), .err_clr(err_clr), .irq(irq)
  );

  // Small translator stand-in: letters a..i honour shift, digits ignore it.
  function automatic logic [7:0] xlate(input logic [7:0] k, input logic s);
    logic [7:0] lc;
    case (k)
      8'h1C: lc = 8'h61;
      8'h32: lc = 8'h62;
      8'h21: lc = 8'h63;
      8'h23: lc = 8'h64;
      8'h24: lc = 8'h65;
      8'h2B: lc = 8'h66;
      8'h34: lc = 8'h67;
      8'h33: lc = 8'h68;
      8'h43: lc = 8'h69;
      8'h16: return 8'h31;
      8'h1E: return 8'h32;
      default: return 8'h00;
    endcase
    return s ? (lc - 8'h20) : lc;
  endfunction

  assign ascii_in = xlate(key_out, shift_out);

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: prefix flags, shift keys, pending translation, queue.
  logic [7:0] q[$];
  bit         m_brk, m_ext, m_lk, m_l, m_r, m_ovf, m_drop;
  logic [7:0] m_key;
  bit         chk_en = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_brk = 0; m_ext = 0; m_lk = 0; m_l = 0; m_r = 0;
      m_ovf = 0; m_drop = 0; m_key = 8'h00;
    end else begin
      bit         do_pop, set_ovf, set_drop;
      logic [7:0] a;
      do_pop = rd_en && (q.size() > 0);
      set_ovf = 0; set_drop = 0;
      if (do_pop) void'(q.pop_front());
      if (m_lk) begin
        a = xlate(m_key, m_l | m_r);
        if (a != 8'h00) begin
          if (q.size() < DEPTH) q.push_back(a);
          else set_ovf = 1;
        end
        if (scan_valid) set_drop = 1;
        m_lk = 0;
      end else if (scan_valid) begin
        if (m_ext && m_brk) begin
          m_ext = 0; m_brk = 0;
        end else if (m_brk) begin
          if (scan_code == 8'h12) m_l = 0;
          if (scan_code == 8'h59) m_r = 0;
          m_brk = 0;
        end else if (m_ext) begin
          if (scan_code == 8'hF0) m_brk = 1;
          else m_ext = 0;
        end else begin
          case (scan_code)
            8'hF0: m_brk = 1;
            8'hE0: m_ext = 1;
            8'h12: m_l = 1;
            8'h59: m_r = 1;
            default: begin m_lk = 1; m_key = scan_code; end
          endcase
        end
      end
      if (err_clr) begin m_ovf = 0; m_drop = 0; end
      if (set_ovf)  m_ovf = 1;
      if (set_drop) m_drop = 1;
    end
  end

  // Every-cycle comparison, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_data", rd_data, (q.size() > 0) ? q[0] : 8'h00);
      chk("empty", {7'd0, empty}, {7'd0, q.size() == 0});
      chk("full", {7'd0, full}, {7'd0, q.size() == DEPTH});
      chk("irq", {7'd0, irq}, {7'd0, q.size() != 0});
      chk("ovf", {7'd0, ovf}, {7'd0, m_ovf});
      chk("drop", {7'd0, drop}, {7'd0, m_drop});
      chk("shift_out", {7'd0, shift_out}, {7'd0, m_l | m_r});
      if (m_lk) chk("key_out", key_out, m_key);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_code  = b;
    tick(1);
    scan_valid = 1'b0;
  endtask

  task automatic key(input logic [7:0] b);
    send(b);
    tick(1);
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  logic [7:0] seq [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
  logic [7:0] drain_exp [8] = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h31};

  initial begin
    rst_n = 1'b0; scan_valid = 1'b0; scan_code = 8'h00;
    rd_en = 1'b0; err_clr = 1'b0;
    tick(2);
    rst_n = 1'b1;
    chk_en = 1;
    chk("reset empty", {7'd0, empty}, 8'h01);
    chk("reset rd_data", rd_data, 8'h00);
    chk("reset irq", {7'd0, irq}, 8'h00);
    chk("reset key_out", key_out, 8'h00);

    // Plain key, latency N+2
    send(8'h1C);
    chk("lookup key_out", key_out, 8'h1C);
    chk("lookup shift", {7'd0, shift_out}, 8'h00);
    chk("lookup empty", {7'd0, empty}, 8'h01);
    tick(1);
    chk("a head", rd_data, 8'h61);
    chk("a nonempty", {7'd0, empty}, 8'h00);
    pop1();
    chk("a popped", rd_data, 8'h00);

    // Shift handling
    send(8'h12); key(8'h1C); send(8'hF0); send(8'h12); key(8'h1C);
    tick(1);
    chk("shift A", rd_data, 8'h41);
    pop1();
    chk("then a", rd_data, 8'h61);
    pop1();
    send(8'h59); key(8'h16); send(8'hF0); send(8'h59);
    tick(1);
    chk("digit 1", rd_data, 8'h31);
    pop1();

    // Releases and extended keys, shift held across them
    send(8'h12);
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    tick(2);
    chk("no push ext", {7'd0, empty}, 8'h01);
    chk("shift kept", {7'd0, shift_out}, 8'h01);
    send(8'hF0); send(8'h12);
    chk("shift released", {7'd0, shift_out}, 8'h00);

    // Unmapped key, byte during LOOKUP
    key(8'h05);
    chk("unmapped", {7'd0, empty}, 8'h01);
    send(8'h1C); send(8'h1C);
    tick(1);
    chk("drop set", {7'd0, drop}, 8'h01);
    chk("one push", rd_data, 8'h61);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("drop cleared", {7'd0, drop}, 8'h00);
    pop1();
    chk("single entry", {7'd0, empty}, 8'h01);

    // Fill past capacity
    for (int i = 0; i < 9; i++) begin
      key(seq[i]);
      if (i == 7) chk("full after 8", {7'd0, full}, 8'h01);
    end
    chk("ovf after 9", {7'd0, ovf}, 8'h01);
    chk("head intact", rd_data, 8'h61);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("ovf cleared", {7'd0, ovf}, 8'h00);

    // Push and pop together while full
    send(8'h16);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    chk("still full", {7'd0, full}, 8'h01);
    chk("ovf unchanged", {7'd0, ovf}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      chk("drain order", rd_data, drain_exp[i]);
      pop1();
    end
    chk("drained", {7'd0, empty}, 8'h01);

    // Reset in the middle of a break sequence
    send(8'h12); send(8'hF0);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    chk("rst shift", {7'd0, shift_out}, 8'h00);
    chk("rst empty", {7'd0, empty}, 8'h01);
    key(8'h1C);
    chk("post-rst a", rd_data, 8'h61);
    pop1();
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
